alu_dispatcher: RTL and testbench
=================================

ALU_DISPATCHER -- requirements
Module: alu_dispatcher

Interface
REQ-001 SHALL have parameter LANES, default 16, number of FP16 lanes per vector.
REQ-002 SHALL have parameter RES_DEPTH, default 8, result FIFO entries (power of two).
REQ-003 SHALL have ports: clk  input  1  single clock, rising edge.
REQ-004 SHALL have: rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have: cmd_valid input 1, cmd_ready output 1  command handshake.
REQ-006 SHALL have: cmd_opmode input 6, cmd_base input 8, cmd_len input 8  opmode, first vector address, vector count.
REQ-007 SHALL have: rd_en output 1, rd_addr output 8  operand buffer read request.
REQ-008 SHALL have: rd_a, rd_b, rd_c  input  16*LANES each  operand data, valid exactly one cycle after rd_en.
REQ-009 SHALL have: alu_in_valid output 1, alu_opmode output 6, alu_a/alu_b/alu_c output 16*LANES  ALU array drive.
REQ-010 SHALL have: alu_out input 16*LANES, alu_out_valid input 1  ALU array results, in issue order.
REQ-011 SHALL have: res_valid output 1, res_ready input 1, res_addr output 8, res_data output 16*LANES  result write-back.
REQ-012 SHALL have: busy output 1, done output 1 (one-cycle pulse), ovf output 1 (sticky overflow).

Function
REQ-013 SHALL implement states IDLE, ISSUE, DRAIN; cmd_ready=1 only in IDLE.
REQ-014 IDLE, cmd_valid=1: latch opmode/base/len; len!=0 -> ISSUE; len==0 -> pulse done next cycle, stay IDLE.
REQ-015 alu_opmode SHALL equal latched opmode, stable for the whole command until next accept.
REQ-016 ISSUE: rd_en=1 in a cycle iff issued<len and outstanding<RES_DEPTH; rd_addr=base+issued (mod 256).
REQ-017 alu_in_valid SHALL be rd_en delayed one cycle; alu_a/b/c driven directly from rd_a/b/c.
REQ-018 outstanding = vectors issued but not yet popped at result port; +1 on rd_en, -1 on res pop, unchanged when both in same cycle.
REQ-019 After issued==len, ISSUE -> DRAIN at next edge.
REQ-020 alu_out_valid=1 SHALL push alu_out into result FIFO; ALU latency is not assumed by the dispatcher.
REQ-021 res_valid=1 iff FIFO non-empty; res_data=FIFO head; pop on res_valid&res_ready.
REQ-022 res_addr = base + popped count (mod 256); results written in issue order.
REQ-023 FIFO push and pop in same cycle SHALL both occur, including when full (pop frees slot) or empty (no bypass; data appears next cycle).
REQ-024 DRAIN -> IDLE when popped==len; done=1 for exactly the cycle after the final pop.
REQ-025 busy=1 in ISSUE and DRAIN, 0 in IDLE.
REQ-026 alu_out_valid with FIFO full and no pop, or in IDLE with outstanding==0: data dropped, ovf set to 1 until reset.
REQ-027 Throughput: with res_ready held 1, one vector issued per cycle, no bubbles.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, clear counters and FIFO, outputs: cmd_ready=1 when released, rd_en=0, alu_in_valid=0, res_valid=0, busy=0, done=0, ovf=0, alu_opmode=0.
REQ-029 Reset mid-command SHALL abort it without done; ALU results arriving later with outstanding==0 follow REQ-026.

Verification
REQ-030 len=4, base=0x10, res_ready=1, ALU model latency 5 -> rd_addr 0x10..0x13 consecutive cycles, res_addr 0x10..0x13 in order, single done pulse after 4th pop.
REQ-031 len=20, res_ready=0 -> rd_en stops after 8 issues, FIFO fills to 8, ovf stays 0; res_ready=1 -> issue resumes, all 20 results delivered, done once.
REQ-032 len=0 -> cmd accepted, done pulse next cycle, rd_en never asserted, busy stays 0.
REQ-033 base=0xFE, len=3 -> rd_addr 0xFE,0xFF,0x00; res_addr same sequence.
REQ-034 rst asserted mid-ISSUE of len=10 -> outputs zero same cycle, no done; next command len=2 completes normally.
REQ-035 Inject alu_out_valid in IDLE -> ovf=1, res_valid stays 0, ovf clears only on rst.

Source files
------------

// File: rtl/alu_dispatcher.sv
// rtl/alu_dispatcher.sv - vector ALU command dispatcher with in-order result FIFO
module alu_dispatcher #(
    parameter int LANES     = 16,
    parameter int RES_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [5:0]           cmd_opmode,
    input  logic [7:0]           cmd_base,
    input  logic [7:0]           cmd_len,
    output logic                 rd_en,
    output logic [7:0]           rd_addr,
    input  logic [16*LANES-1:0]  rd_a,
    input  logic [16*LANES-1:0]  rd_b,
    input  logic [16*LANES-1:0]  rd_c,
    output logic                 alu_in_valid,
    output logic [5:0]           alu_opmode,
    output logic [16*LANES-1:0]  alu_a,
    output logic [16*LANES-1:0]  alu_b,
    output logic [16*LANES-1:0]  alu_c,
    input  logic [16*LANES-1:0]  alu_out,
    input  logic                 alu_out_valid,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [7:0]           res_addr,
    output logic [16*LANES-1:0]  res_data,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf
);
    localparam int W  = 16 * LANES;
    localparam int AW = $clog2(RES_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(RES_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [5:0]    opmode_q, opmode_d;
    logic [7:0]    base_q, base_d, len_q, len_d;
    logic [7:0]    issued_q, issued_d, popped_q, popped_d;
    logic [AW:0]   outst_q, outst_d, count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          done_q, done_d, ovf_q, ovf_d, in_valid_q;
    logic [W-1:0]  mem_q [RES_DEPTH];
    logic          issue, pop, push, drop, fifo_full, fifo_empty;

    always_comb begin
        fifo_full  = (count_q == DEPTH_C);
        fifo_empty = (count_q == '0);
        pop        = !fifo_empty && res_ready;
        // Capping outstanding at the FIFO depth guarantees every in-flight result has a slot.
        issue      = (state_q == S_ISSUE) && (issued_q < len_q) && (outst_q < DEPTH_C);
        drop       = alu_out_valid && ((fifo_full && !pop) || (state_q == S_IDLE && outst_q == '0));
        push       = alu_out_valid && !drop;

        state_d  = state_q;
        opmode_d = opmode_q;
        base_d   = base_q;
        len_d    = len_q;
        issued_d = issued_q + {7'b0, issue};
        popped_d = popped_q + {7'b0, pop};
        outst_d  = outst_q;
        count_d  = count_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q | drop;

        if (issue && !pop)
            outst_d = outst_q + 1'b1;
        else if (!issue && pop && outst_q != '0)
            outst_d = outst_q - 1'b1;

        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (!push && pop)
            count_d = count_q - 1'b1;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    opmode_d = cmd_opmode;
                    base_d   = cmd_base;
                    len_d    = cmd_len;
                    issued_d = '0;
                    popped_d = '0;
                    if (cmd_len != 8'd0)
                        state_d = S_ISSUE;
                    else
                        done_d = 1'b1;
                end
            end
            S_ISSUE: begin
                if (issued_q == len_q)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (pop && (popped_q + 8'd1 == len_q)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            opmode_q   <= '0;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            popped_q   <= '0;
            outst_q    <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            in_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            opmode_q   <= opmode_d;
            base_q     <= base_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            popped_q   <= popped_d;
            outst_q    <= outst_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            in_valid_q <= issue;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= alu_out;
    end

    assign cmd_ready    = (state_q == S_IDLE);
    assign rd_en        = issue;
    assign rd_addr      = base_q + issued_q;
    assign alu_in_valid = in_valid_q;
    assign alu_opmode   = opmode_q;
    assign alu_a        = rd_a;
    assign alu_b        = rd_b;
    assign alu_c        = rd_c;
    assign res_valid    = !fifo_empty;
    assign res_addr     = base_q + popped_q;
    assign res_data     = mem_q[rd_ptr_q];
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign ovf          = ovf_q;
endmodule

// File: tb/tb_alu_dispatcher.sv
// tb/tb_alu_dispatcher.sv - randomized self-checking bench for alu_dispatcher
module tb_alu_dispatcher;
    localparam int LANES = 16;
    localparam int W     = 16 * LANES;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [5:0]   cmd_opmode = '0;
    logic [7:0]   cmd_base = '0;
    logic [7:0]   cmd_len = '0;
    logic         rd_en;
    logic [7:0]   rd_addr;
    logic [W-1:0] rd_a, rd_b, rd_c;
    logic         alu_in_valid;
    logic [5:0]   alu_opmode;
    logic [W-1:0] alu_a, alu_b, alu_c;
    logic [W-1:0] alu_out;
    logic         alu_out_valid;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [7:0]   res_addr;
    logic [W-1:0] res_data;
    logic         busy, done, ovf;

    alu_dispatcher #(.LANES(LANES), .RES_DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opmode(cmd_opmode), .cmd_base(cmd_base), .cmd_len(cmd_len),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_a(rd_a), .rd_b(rd_b), .rd_c(rd_c),
        .alu_in_valid(alu_in_valid), .alu_opmode(alu_opmode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .alu_out(alu_out), .alu_out_valid(alu_out_valid),
        .res_valid(res_valid), .res_ready(res_ready), .res_addr(res_addr), .res_data(res_data),
        .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Operand buffer contents and the ALU function define every expected result.
    logic [W-1:0] ma [256];
    logic [W-1:0] mb [256];
    logic [W-1:0] mc [256];

    function automatic logic [W-1:0] exp_data(input logic [7:0] a, input logic [5:0] op);
        return ma[a] ^ mb[a] ^ mc[a] ^ {LANES{{10'b0, op}}};
    endfunction

    always @(posedge clk) begin
        if (rd_en) begin
            rd_a <= ma[rd_addr];
            rd_b <= mb[rd_addr];
            rd_c <= mc[rd_addr];
        end
    end

    int           alu_lat = 1;
    logic         inj_v = 1'b0;
    logic [W-1:0] inj_d = '0;
    logic         pv [8] = '{default: 1'b0};
    logic [W-1:0] pd [8];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= alu_in_valid;
            pd[0] <= alu_a ^ alu_b ^ alu_c ^ {LANES{{10'b0, alu_opmode}}};
            for (int i = 1; i < 8; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign alu_out_valid = pv[alu_lat-1] | inj_v;
    assign alu_out       = inj_v ? inj_d : pd[alu_lat-1];

    int         cyc = 0;
    logic [7:0] rd_log [$];
    int         rd_cyc [$];
    logic [7:0] pop_addr [$];
    logic [W-1:0] pop_data [$];
    int         pop_cyc [$];
    int         done_cnt = 0, done_cyc = 0, busy_seen = 0, opm_err = 0, acc_cyc = 0;
    logic [5:0] cur_op = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rd_en) begin
            rd_log.push_back(rd_addr);
            rd_cyc.push_back(cyc);
        end
        if (res_valid && res_ready) begin
            pop_addr.push_back(res_addr);
            pop_data.push_back(res_data);
            pop_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_seen++;
        if (alu_in_valid && alu_opmode !== cur_op) opm_err++;
    end

    task automatic clear_logs();
        rd_log.delete(); rd_cyc.delete();
        pop_addr.delete(); pop_data.delete(); pop_cyc.delete();
        done_cnt = 0; busy_seen = 0;
    endtask

    // rmode: 0 = res_ready held high, 1 = random res_ready
    task automatic run_cmd(input logic [5:0] op, input logic [7:0] base, input logic [7:0] len,
                           input int lat, input int rmode, input int budget, output bit timed_out);
        clear_logs();
        alu_lat = lat;
        cur_op = op;
        cmd_opmode = op; cmd_base = base; cmd_len = len; cmd_valid = 1'b1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        acc_cyc = cyc;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (rmode == 1) res_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (done_cnt > 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        res_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        n_checks++; if ({rd_en, alu_in_valid, res_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_valids got=%b exp=000", {rd_en, alu_in_valid, res_valid}); end
        n_checks++; if ({busy, done, ovf} !== 3'b000) begin n_fail++; $display("FAIL reset_status got=%b exp=000", {busy, done, ovf}); end
        n_checks++; if (alu_opmode !== 6'd0) begin n_fail++; $display("FAIL reset_opmode got=%0h exp=0", alu_opmode); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_release got=%b%b exp=10", cmd_ready, busy); end
    endtask

    task automatic test_basic();
        bit to;
        logic [5:0] op;
        op = 6'($urandom);
        run_cmd(op, 8'h10, 8'd4, 5, 0, 200, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL basic_timeout got=no_done exp=done"); end
        n_checks++; if (rd_log.size() != 4) begin n_fail++; $display("FAIL basic_rd_count got=%0d exp=4", rd_log.size()); end
        for (int i = 0; i < rd_log.size() && i < 4; i++) begin
            n_checks++;
            if (rd_log[i] !== 8'(8'h10 + i) || rd_cyc[i] != rd_cyc[0] + i) begin
                n_fail++; $display("FAIL basic_rd_addr[%0d] got=%0h@%0d exp=%0h@%0d", i, rd_log[i], rd_cyc[i], 8'(8'h10 + i), rd_cyc[0] + i);
            end
        end
        n_checks++; if (pop_addr.size() != 4) begin n_fail++; $display("FAIL basic_pop_count got=%0d exp=4", pop_addr.size()); end
        for (int i = 0; i < pop_addr.size() && i < 4; i++) begin
            n_checks++;
            if (pop_addr[i] !== 8'(8'h10 + i) || pop_data[i] !== exp_data(8'(8'h10 + i), op)) begin
                n_fail++; $display("FAIL basic_result[%0d] got_addr=%0h exp_addr=%0h data_ok=%0b", i, pop_addr[i], 8'(8'h10 + i), pop_data[i] === exp_data(8'(8'h10 + i), op));
            end
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
        if (pop_cyc.size() > 0) begin
            n_checks++; if (done_cyc != pop_cyc[pop_cyc.size()-1] + 1) begin n_fail++; $display("FAIL basic_done_timing got=%0d exp=%0d", done_cyc, pop_cyc[pop_cyc.size()-1] + 1); end
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] op;
        bit to;
        op = 6'($urandom);
        clear_logs();
        alu_lat = 3; cur_op = op; res_ready = 1'b0;
        cmd_opmode = op; cmd_base = 8'h30; cmd_len = 8'd20; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        n_checks++; if (rd_log.size() != 8) begin n_fail++; $display("FAIL bp_stall_issues got=%0d exp=8", rd_log.size()); end
        n_checks++; if (res_valid !== 1'b1 || ovf !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_stall_status got=v%b o%b b%b exp=v1 o0 b1", res_valid, ovf, busy); end
        res_ready = 1'b1;
        to = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (done_cnt > 0) begin to = 1'b0; break; end
        end
        repeat (6) @(posedge clk);
        #1;
        n_checks++; if (to) begin n_fail++; $display("FAIL bp_timeout got=no_done exp=done"); end
        n_checks++; if (rd_log.size() != 20 || pop_addr.size() != 20) begin n_fail++; $display("FAIL bp_counts got=rd%0d pop%0d exp=20/20", rd_log.size(), pop_addr.size()); end
        for (int i = 0; i < pop_addr.size() && i < 20; i++) begin
            n_checks++;
            if (pop_addr[i] !== 8'(8'h30 + i) || pop_data[i] !== exp_data(8'(8'h30 + i), op)) begin
                n_fail++; $display("FAIL bp_result[%0d] got_addr=%0h exp_addr=%0h", i, pop_addr[i], 8'(8'h30 + i));
            end
        end
        n_checks++; if (done_cnt != 1 || ovf !== 1'b0) begin n_fail++; $display("FAIL bp_done_ovf got=d%0d o%b exp=d1 o0", done_cnt, ovf); end
    endtask

    task automatic test_len0();
        bit to;
        run_cmd(6'h2a, 8'h55, 8'd0, 2, 0, 20, to);
        n_checks++; if (to || done_cnt != 1) begin n_fail++; $display("FAIL len0_done got=%0d exp=1", done_cnt); end
        n_checks++; if (done_cyc != acc_cyc) begin n_fail++; $display("FAIL len0_done_timing got=%0d exp=%0d", done_cyc, acc_cyc); end
        n_checks++; if (rd_log.size() != 0 || busy_seen != 0) begin n_fail++; $display("FAIL len0_quiet got=rd%0d busy%0d exp=0/0", rd_log.size(), busy_seen); end
    endtask

    task automatic test_wrap();
        bit to;
        logic [5:0] op;
        logic [7:0] exp_a [3];
        op = 6'($urandom);
        exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00;
        run_cmd(op, 8'hFE, 8'd3, 2, 0, 200, to);
        n_checks++; if (to || rd_log.size() != 3 || pop_addr.size() != 3) begin n_fail++; $display("FAIL wrap_counts got=rd%0d pop%0d exp=3/3", rd_log.size(), pop_addr.size()); end
        for (int i = 0; i < 3 && i < rd_log.size() && i < pop_addr.size(); i++) begin
            n_checks++;
            if (rd_log[i] !== exp_a[i] || pop_addr[i] !== exp_a[i] || pop_data[i] !== exp_data(exp_a[i], op)) begin
                n_fail++; $display("FAIL wrap_addr[%0d] got=rd%0h res%0h exp=%0h", i, rd_log[i], pop_addr[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        logic [5:0] op;
        op = 6'($urandom);
        clear_logs();
        alu_lat = 4; cur_op = op; res_ready = 1'b1;
        cmd_opmode = op; cmd_base = 8'h50; cmd_len = 8'd10; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b1 || rd_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_active got=b%b r%b exp=11", busy, rd_en); end
        rst = 1'b1;
        #1;
        n_checks++; if ({rd_en, alu_in_valid, res_valid, busy, done} !== 5'b0) begin n_fail++; $display("FAIL rstmid_outputs got=%b exp=00000", {rd_en, alu_in_valid, res_valid, busy, done}); end
        n_checks++; if (cmd_ready !== 1'b1 || alu_opmode !== 6'd0) begin n_fail++; $display("FAIL rstmid_ready got=%b/%0h exp=1/0", cmd_ready, alu_opmode); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL rstmid_no_done got=%0d exp=0", done_cnt); end
        op = 6'($urandom);
        run_cmd(op, 8'h60, 8'd2, 3, 0, 200, to);
        n_checks++; if (to || done_cnt != 1 || pop_addr.size() != 2) begin n_fail++; $display("FAIL rstmid_next got=d%0d p%0d exp=1/2", done_cnt, pop_addr.size()); end
        for (int i = 0; i < pop_addr.size() && i < 2; i++) begin
            n_checks++;
            if (pop_addr[i] !== 8'(8'h60 + i) || pop_data[i] !== exp_data(8'(8'h60 + i), op)) begin
                n_fail++; $display("FAIL rstmid_result[%0d] got_addr=%0h exp_addr=%0h", i, pop_addr[i], 8'(8'h60 + i));
            end
        end
    endtask

    task automatic test_ovf();
        bit to;
        logic [5:0] op;
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_initial got=%b exp=0", ovf); end
        inj_d = {8{32'($urandom)}};
        inj_v = 1'b1;
        @(posedge clk); #1;
        inj_v = 1'b0;
        n_checks++; if (ovf !== 1'b1 || res_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_inject got=o%b v%b exp=o1 v0", ovf, res_valid); end
        op = 6'($urandom);
        run_cmd(op, 8'h80, 8'd3, 2, 0, 200, to);
        n_checks++; if (to || pop_addr.size() != 3 || ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=p%0d o%b exp=p3 o1", pop_addr.size(), ovf); end
        for (int i = 0; i < pop_addr.size() && i < 3; i++) begin
            n_checks++;
            if (pop_data[i] !== exp_data(8'(8'h80 + i), op)) begin n_fail++; $display("FAIL ovf_result[%0d] got_addr=%0h exp_addr=%0h", i, pop_addr[i], 8'(8'h80 + i)); end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
    endtask

    task automatic test_random();
        bit to;
        logic [5:0] op;
        logic [7:0] base, len;
        int lat;
        opm_err = 0;
        for (int k = 0; k < 6; k++) begin
            op = 6'($urandom); base = 8'($urandom);
            len = 8'($urandom_range(1, 30)); lat = $urandom_range(1, 8);
            run_cmd(op, base, len, lat, 1, 800, to);
            n_checks++; if (to || done_cnt != 1) begin n_fail++; $display("FAIL rand%0d_done got=%0d exp=1", k, done_cnt); end
            n_checks++; if (rd_log.size() != int'(len) || pop_addr.size() != int'(len)) begin n_fail++; $display("FAIL rand%0d_counts got=rd%0d pop%0d exp=%0d", k, rd_log.size(), pop_addr.size(), len); end
            for (int i = 0; i < pop_addr.size() && i < rd_log.size() && i < int'(len); i++) begin
                n_checks++;
                if (rd_log[i] !== 8'(base + i) || pop_addr[i] !== 8'(base + i) || pop_data[i] !== exp_data(8'(base + i), op)) begin
                    n_fail++; $display("FAIL rand%0d_item[%0d] got=rd%0h res%0h exp=%0h", k, i, rd_log[i], pop_addr[i], 8'(base + i));
                end
            end
        end
        n_checks++; if (opm_err != 0 || ovf !== 1'b0) begin n_fail++; $display("FAIL rand_opmode_ovf got=e%0d o%b exp=e0 o0", opm_err, ovf); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            for (int j = 0; j < W / 32; j++) begin
                ma[i][j*32 +: 32] = $urandom;
                mb[i][j*32 +: 32] = $urandom;
                mc[i][j*32 +: 32] = $urandom;
            end
        test_reset();
        test_basic();
        test_backpressure();
        test_len0();
        test_wrap();
        test_reset_mid();
        test_ovf();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
